sprite_draw_scheduler: RTL and testbench

- Per-frame sequencer that shares the single VGA pixel-write port between N_OBJ sprite-draw engines (ship, asteroids, bullets).
- On each frame_tick it visits the enabled objects in index order. For each one it runs an erase pass at the previously drawn position, with colour forced to black, then a draw pass at the new position.
- It muxes the active engine's pixel stream onto the VGA port.
- A per-phase watchdog catches engines that never report done.

---
 rtl/sprite_draw_scheduler.sv | 256 +++++++++++++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_scheduler.sv
// Per-frame sequencer sharing one VGA pixel-write port between N_OBJ sprite engines (erase old, draw new).
// Optional build macro: SPRITE_SCHED_SKIP_UNCHANGED_EN skips objects whose position has not changed.
module sprite_draw_scheduler #(
  parameter int unsigned N_OBJ   = 4,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_tick,
  input  logic [N_OBJ-1:0]       obj_en,
  input  logic [10*N_OBJ-1:0]    obj_x,
  input  logic [10*N_OBJ-1:0]    obj_y,
  input  logic [N_OBJ-1:0]       eng_done,
  input  logic [10*N_OBJ-1:0]    eng_pix_x,
  input  logic [10*N_OBJ-1:0]    eng_pix_y,
  input  logic [3*N_OBJ-1:0]     eng_pix_color,
  input  logic [N_OBJ-1:0]       eng_pix_we,
  input  logic                   clear_status,
  output logic [N_OBJ-1:0]       eng_start,
  output logic [9:0]             eng_x,
  output logic [9:0]             eng_y,
  output logic [9:0]             vga_x,
  output logic [9:0]             vga_y,
  output logic [2:0]             vga_color,
  output logic                   vga_we,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int unsigned IDX_W = $clog2(N_OBJ + 1);
  localparam int unsigned WD_W  = 12;
  localparam int unsigned CW    = 10;
  localparam int unsigned COL_W = 3;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SELECT      = 3'd1;
  localparam logic [2:0] S_ERASE_START = 3'd2;
  localparam logic [2:0] S_ERASE_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAW_START  = 3'd4;
  localparam logic [2:0] S_DRAW_WAIT   = 3'd5;
  localparam logic [2:0] S_NEXT        = 3'd6;
  localparam logic [2:0] S_DONE        = 3'd7;

  logic [2:0]       state, state_d;
  logic [IDX_W-1:0] idx, idx_d;

  logic [N_OBJ-1:0] snap_en;
  logic [CW-1:0]    snap_x [N_OBJ];
  logic [CW-1:0]    snap_y [N_OBJ];
  logic [N_OBJ-1:0] prev_valid;
  logic [CW-1:0]    prev_x [N_OBJ];
  logic [CW-1:0]    prev_y [N_OBJ];
  logic [WD_W-1:0]  wdog;

  logic             sel_en, sel_pv, sel_done, sel_pix_we;
  logic [CW-1:0]    sel_snap_x, sel_snap_y, sel_prev_x, sel_prev_y;
  logic [CW-1:0]    sel_pix_x, sel_pix_y;
  logic [COL_W-1:0] sel_pix_c;

  logic             in_wait, wd_hit, to_fire, draw_ok;
  logic             start_phase_d;
  logic [N_OBJ-1:0] start_d;

  // Everything belonging to the currently indexed object; idx==N_OBJ selects nothing.
  always_comb begin
    sel_en     = 1'b0;
    sel_pv     = 1'b0;
    sel_done   = 1'b0;
    sel_pix_we = 1'b0;
    sel_snap_x = '0;
    sel_snap_y = '0;
    sel_prev_x = '0;
    sel_prev_y = '0;
    sel_pix_x  = '0;
    sel_pix_y  = '0;
    sel_pix_c  = '0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_en     = snap_en[i];
        sel_pv     = prev_valid[i];
        sel_done   = eng_done[i];
        sel_pix_we = eng_pix_we[i];
        sel_snap_x = snap_x[i];
        sel_snap_y = snap_y[i];
        sel_prev_x = prev_x[i];
        sel_prev_y = prev_y[i];
        sel_pix_x  = eng_pix_x[CW*i +: CW];
        sel_pix_y  = eng_pix_y[CW*i +: CW];
        sel_pix_c  = eng_pix_color[COL_W*i +: COL_W];
      end
    end
  end

  assign in_wait = (state == S_ERASE_WAIT) || (state == S_DRAW_WAIT);
  assign wd_hit  = (wdog == WD_W'(TIMEOUT));
  assign to_fire = in_wait && !sel_done && wd_hit;
  assign draw_ok = (state == S_DRAW_WAIT) && sel_done;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_SELECT;
          idx_d   = '0;
        end
      end
      S_SELECT: begin
        if (idx == IDX_W'(N_OBJ)) begin
          state_d = S_DONE;
        end else if (!sel_en) begin
          idx_d = idx + IDX_W'(1);
`ifdef SPRITE_SCHED_SKIP_UNCHANGED_EN
        end else if (sel_pv && (sel_snap_x == sel_prev_x) && (sel_snap_y == sel_prev_y)) begin
          idx_d = idx + IDX_W'(1);
`endif
        end else if (!sel_pv) begin
          state_d = S_DRAW_START;
        end else begin
          state_d = S_ERASE_START;
        end
      end
      S_ERASE_START: state_d = S_ERASE_WAIT;
      S_ERASE_WAIT: begin
        if (sel_done) begin
          state_d = S_DRAW_START;
        end else if (wd_hit) begin
          state_d = S_NEXT;
        end
      end
      S_DRAW_START: state_d = S_DRAW_WAIT;
      S_DRAW_WAIT: begin
        if (sel_done || wd_hit) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        idx_d   = idx + IDX_W'(1);
        state_d = S_SELECT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Start pulse is registered so it coincides with the START state it belongs to.
  always_comb begin
    start_phase_d = (state_d == S_ERASE_START) || (state_d == S_DRAW_START);
    start_d       = '0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      start_d[i] = start_phase_d && (idx_d == IDX_W'(i));
    end
  end

  // Frame snapshot and per-object history of the last drawn position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_en    <= '0;
      prev_valid <= '0;
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        snap_x[i] <= '0;
        snap_y[i] <= '0;
        prev_x[i] <= '0;
        prev_y[i] <= '0;
      end
    end else begin
      if ((state == S_IDLE) && frame_tick) begin
        snap_en <= obj_en;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
          snap_x[i] <= obj_x[CW*i +: CW];
          snap_y[i] <= obj_y[CW*i +: CW];
        end
      end
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        if (idx == IDX_W'(i)) begin
          if (draw_ok) begin
            prev_x[i]     <= sel_snap_x;
            prev_y[i]     <= sel_snap_y;
            prev_valid[i] <= 1'b1;
          end else if (to_fire) begin
            prev_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Per-phase watchdog, saturating at TIMEOUT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog <= '0;
    end else if ((state == S_ERASE_START) || (state == S_DRAW_START)) begin
      wdog <= '0;
    end else if (in_wait && !wd_hit) begin
      wdog <= wdog + WD_W'(1);
    end
  end

  // Registered control outputs and sticky status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_start   <= '0;
      eng_x       <= '0;
      eng_y       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      eng_start  <= start_d;
      busy       <= (state_d != S_IDLE);
      frame_done <= (state_d == S_DONE);
      if (state_d == S_ERASE_START) begin
        eng_x <= sel_prev_x;
        eng_y <= sel_prev_y;
      end else if (state_d == S_DRAW_START) begin
        eng_x <= sel_snap_x;
        eng_y <= sel_snap_y;
      end
      if (frame_tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end else if (clear_status) begin
        overrun <= 1'b0;
      end
      if (to_fire) begin
        timeout_err <= 1'b1;
      end else if (clear_status) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // Zero-latency pixel mux; erase passes write black.
  always_comb begin
    vga_we    = in_wait && sel_pix_we;
    vga_x     = in_wait ? sel_pix_x : '0;
    vga_y     = in_wait ? sel_pix_y : '0;
    vga_color = (state == S_DRAW_WAIT) ? sel_pix_c : '0;
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: N_OBJ=2 with stub engines (one pixel at origin, colour 5, done 10 cycles after start).
module tb_sprite_draw_scheduler;

  localparam int unsigned N  = 2;
  localparam int unsigned TO = 40;

  logic          clk, reset_n, frame_tick, clear_status;
  logic [1:0]    obj_en, eng_done, eng_pix_we, eng_start;
  logic [19:0]   obj_x, obj_y, eng_pix_x, eng_pix_y;
  logic [5:0]    eng_pix_color;
  logic [9:0]    eng_x, eng_y, vga_x, vga_y;
  logic [2:0]    vga_color;
  logic          vga_we, busy, frame_done, overrun, timeout_err;
  logic [1:0]    hang;

  sprite_draw_scheduler #(.N_OBJ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .obj_en(obj_en),
    .obj_x(obj_x), .obj_y(obj_y), .eng_done(eng_done), .eng_pix_x(eng_pix_x),
    .eng_pix_y(eng_pix_y), .eng_pix_color(eng_pix_color), .eng_pix_we(eng_pix_we),
    .clear_status(clear_status), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_we(vga_we),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub engines
  logic       s_act [2];
  logic [3:0] s_cnt [2];
  logic [9:0] s_x [2];
  logic [9:0] s_y [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        s_act[i] <= 1'b0; s_cnt[i] <= '0; s_x[i] <= '0; s_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (eng_start[i]) begin
          s_act[i] <= 1'b1; s_cnt[i] <= 4'd1; s_x[i] <= eng_x; s_y[i] <= eng_y;
        end else if (s_act[i]) begin
          if (s_cnt[i] == 4'd10) s_act[i] <= 1'b0;
          else s_cnt[i] <= s_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    eng_done = '0; eng_pix_we = '0; eng_pix_x = '0; eng_pix_y = '0; eng_pix_color = '0;
    for (int i = 0; i < 2; i++) begin
      eng_done[i]             = s_act[i] && (s_cnt[i] == 4'd10) && !hang[i];
      eng_pix_we[i]           = s_act[i] && (s_cnt[i] == 4'd5);
      eng_pix_x[10*i +: 10]   = s_x[i];
      eng_pix_y[10*i +: 10]   = s_y[i];
      eng_pix_color[3*i +: 3] = 3'b101;
    end
  end

  // Output monitor, sampled on the falling edge
  logic [21:0] st_q [$];
  logic [22:0] px_q [$];
  int busy_cnt, fd_cnt;

  always @(negedge clk) begin
    if (eng_start != 2'b00) st_q.push_back({eng_start, eng_x, eng_y});
    if (vga_we) px_q.push_back({vga_x, vga_y, vga_color});
    if (busy) busy_cnt++;
    if (frame_done) fd_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]       en;
    logic [9:0]       x0, y0, x1, y1;
    logic [1:0]       hang;
    int               n_st;
    logic [3:0][21:0] st;
    int               n_px;
    logic [3:0][22:0] px;
    int               cyc;
    logic             to_err;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [21:0] sv(input int s, input int x, input int y);
    return {2'(s), 10'(x), 10'(y)};
  endfunction

  function automatic logic [22:0] pv(input int x, input int y, input int c);
    return {10'(x), 10'(y), 3'(c)};
  endfunction

  function automatic vec_t mk(input logic [1:0] en, input int x0, input int y0, input int x1,
                              input int y1, input logic [1:0] hg, input int cyc, input logic te);
    vec_t v;
    v.en = en; v.x0 = 10'(x0); v.y0 = 10'(y0); v.x1 = 10'(x1); v.y1 = 10'(y1);
    v.hang = hg; v.cyc = cyc; v.to_err = te;
    v.n_st = 0; v.st = '0; v.n_px = 0; v.px = '0;
    return v;
  endfunction

  task automatic drive_frame(input int k);
    @(posedge clk); #1;
    st_q.delete(); px_q.delete(); busy_cnt = 0; fd_cnt = 0;
    @(negedge clk);
    obj_en = tbl[k].en; obj_x = {tbl[k].x1, tbl[k].x0}; obj_y = {tbl[k].y1, tbl[k].y0};
    hang = tbl[k].hang; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic run_frame(input int k);
    int n;
    drive_frame(k);
    n = 0;
    while (fd_cnt == 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) $display("FAIL f%0d_timeout: no frame_done within %0d cycles", k, n);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("f%0d_nstart", k), 64'(st_q.size()), 64'(tbl[k].n_st));
    for (int i = 0; i < tbl[k].n_st; i++)
      chk($sformatf("f%0d_start%0d", k, i), (i < st_q.size()) ? 64'(st_q[i]) : 64'hdead, 64'(tbl[k].st[i]));
    chk($sformatf("f%0d_npix", k), 64'(px_q.size()), 64'(tbl[k].n_px));
    for (int i = 0; i < tbl[k].n_px; i++)
      chk($sformatf("f%0d_pix%0d", k, i), (i < px_q.size()) ? 64'(px_q[i]) : 64'hdead, 64'(tbl[k].px[i]));
    chk($sformatf("f%0d_busy_cycles", k), 64'(busy_cnt), 64'(tbl[k].cyc));
    chk($sformatf("f%0d_frame_done_pulses", k), 64'(fd_cnt), 64'd1);
    chk($sformatf("f%0d_timeout_err", k), 64'(timeout_err), 64'(tbl[k].to_err));
    chk($sformatf("f%0d_busy_after", k), 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b1; frame_tick = 1'b0; clear_status = 1'b0; hang = '0;
    obj_en = '0; obj_x = '0; obj_y = '0;

    // Frame table
    tbl[0] = mk(2'b11, 100, 50, 200, 60, 2'b00, 28, 1'b0);
    tbl[0].n_st = 2; tbl[0].st[0] = sv(1, 100, 50); tbl[0].st[1] = sv(2, 200, 60);
    tbl[0].n_px = 2; tbl[0].px[0] = pv(100, 50, 5); tbl[0].px[1] = pv(200, 60, 5);
    tbl[1] = mk(2'b11, 104, 50, 200, 60, 2'b00, 50, 1'b0);
    tbl[1].st[0] = sv(1, 100, 50); tbl[1].st[1] = sv(1, 104, 50);
    tbl[1].st[2] = sv(2, 200, 60); tbl[1].st[3] = sv(2, 200, 60);
    tbl[1].px[0] = pv(100, 50, 0); tbl[1].px[1] = pv(104, 50, 5);
    tbl[1].px[2] = pv(200, 60, 0); tbl[1].px[3] = pv(200, 60, 5);
`ifdef SPRITE_SCHED_SKIP_UNCHANGED_EN
    tbl[1].n_st = 2; tbl[1].n_px = 2; tbl[1].cyc = 27;
`else
    tbl[1].n_st = 4; tbl[1].n_px = 4;
`endif
    tbl[2] = mk(2'b01, 108, 52, 300, 70, 2'b00, 27, 1'b0);
    tbl[2].n_st = 2; tbl[2].st[0] = sv(1, 104, 50); tbl[2].st[1] = sv(1, 108, 52);
    tbl[2].n_px = 2; tbl[2].px[0] = pv(104, 50, 0); tbl[2].px[1] = pv(108, 52, 5);
    tbl[3] = mk(2'b10, 108, 52, 210, 65, 2'b10, TO + 7, 1'b1);
    tbl[3].n_st = 1; tbl[3].st[0] = sv(2, 200, 60);
    tbl[3].n_px = 1; tbl[3].px[0] = pv(200, 60, 0);
    tbl[4] = mk(2'b10, 108, 52, 210, 65, 2'b00, 16, 1'b1);
    tbl[4].n_st = 1; tbl[4].st[0] = sv(2, 210, 65);
    tbl[4].n_px = 1; tbl[4].px[0] = pv(210, 65, 5);
    tbl[5] = mk(2'b01, 112, 52, 210, 65, 2'b00, 27, 1'b0);
    tbl[5].n_st = 2; tbl[5].st[0] = sv(1, 108, 52); tbl[5].st[1] = sv(1, 112, 52);
    tbl[5].n_px = 2; tbl[5].px[0] = pv(108, 52, 0); tbl[5].px[1] = pv(112, 52, 5);
    tbl[6] = mk(2'b11, 120, 40, 220, 80, 2'b00, 28, 1'b0);
    tbl[6].n_st = 2; tbl[6].st[0] = sv(1, 120, 40); tbl[6].st[1] = sv(2, 220, 80);
    tbl[6].n_px = 2; tbl[6].px[0] = pv(120, 40, 5); tbl[6].px[1] = pv(220, 80, 5);

    #1 reset_n = 1'b0;
    #1;
    chk("reset_outputs", 64'({eng_start, eng_x, eng_y, vga_x, vga_y, vga_color, vga_we,
                              busy, frame_done, overrun, timeout_err}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 5; k++) run_frame(k);

    // Sticky clear, then tick mid-pass and tick-with-clear collisions
    @(negedge clk); clear_status = 1'b1;
    @(negedge clk); clear_status = 1'b0;
    chk("timeout_err_cleared", 64'(timeout_err), 64'd0);
    fork
      run_frame(5);
      begin
        n = 0;
        while (n < 100) begin
          @(negedge clk);
          if (busy) break;
          n++;
        end
        repeat (2) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        chk("overrun_set", 64'(overrun), 64'd1);
        clear_status = 1'b1;
        @(negedge clk); clear_status = 1'b0;
        chk("overrun_cleared", 64'(overrun), 64'd0);
        frame_tick = 1'b1; clear_status = 1'b1;
        @(negedge clk); frame_tick = 1'b0; clear_status = 1'b0;
        chk("overrun_set_beats_clear", 64'(overrun), 64'd1);
      end
    join
    repeat (20) @(posedge clk);
    #1;
    chk("no_second_pass_busy", 64'(busy), 64'd0);
    chk("no_second_pass_done", 64'(fd_cnt), 64'd1);

    // Asynchronous reset while a draw pass is in flight
    drive_frame(5);
    n = 0;
    while (st_q.size() < 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_reset", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({eng_start, eng_x, eng_y, vga_x, vga_y, vga_color, vga_we,
                                    busy, frame_done, overrun, timeout_err}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_frame(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
